// File: rtl/i2s_tx.sv
// I2S transmitter: single-entry holding register feeding a 64-BCK stereo frame,
// MSB first with the standard one-BCK delay after each LRCK transition.
module i2s_tx #(
    parameter int BCK_HALF = 8,
    parameter int AUDIO_DW = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [AUDIO_DW-1:0] left_in,
    input  logic [AUDIO_DW-1:0] right_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                underrun,
    output logic                I2S_BCK,
    output logic                I2S_LRCK,
    output logic                I2S_DATA
);

    localparam int               DIV_W    = (BCK_HALF > 2) ? $clog2(BCK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCK_HALF - 1);
    localparam logic [4:0]       LAST_POS = 5'(AUDIO_DW);

    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic                pending;
    logic [AUDIO_DW-1:0] hold_l, hold_r;
    logic [AUDIO_DW-1:0] last_l, last_r;
    logic [AUDIO_DW-1:0] shift_l, shift_r;

    logic       div_wrap;
    logic       fall_tick;
    logic       frame_load;
    logic       capture;
    logic [5:0] next_bit;
    logic [4:0] next_pos;

    assign div_wrap   = (div_cnt == DIV_MAX);
    assign fall_tick  = div_wrap & I2S_BCK;
    assign frame_load = fall_tick & (bit_cnt == 6'd63);
    assign next_bit   = bit_cnt + 6'd1;
    assign next_pos   = next_bit[4:0];
    assign in_ready   = ~pending;
    assign capture    = in_valid & ~pending;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values and evaluation order inside the block is irrelevant.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_cnt  <= '0;
            bit_cnt  <= 6'd63;
            I2S_BCK  <= 1'b0;
            I2S_LRCK <= 1'b1;
            I2S_DATA <= 1'b0;
            underrun <= 1'b0;
            pending  <= 1'b0;
            // NOTE: the sample registers are reset too, so the underrun frame that
            // follows reset repeats an all-zero pair instead of stale audio.
            hold_l   <= '0;
            hold_r   <= '0;
            last_l   <= '0;
            last_r   <= '0;
            shift_l  <= '0;
            shift_r  <= '0;
        end else begin
            underrun <= 1'b0;
            div_cnt  <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) begin
                I2S_BCK <= ~I2S_BCK;
            end

            if (fall_tick) begin
                bit_cnt  <= next_bit;
                I2S_LRCK <= next_bit[5];
                if (frame_load) begin
                    I2S_DATA <= 1'b0;
                    if (pending) begin
                        shift_l <= hold_l;
                        shift_r <= hold_r;
                        last_l  <= hold_l;
                        last_r  <= hold_r;
                    end else begin
                        shift_l  <= last_l;
                        shift_r  <= last_r;
                        underrun <= 1'b1;
                    end
                end else if (next_pos != 5'd0 && next_pos <= LAST_POS) begin
                    // Position 0 of each slot is the one-BCK delay bit.
                    if (next_bit[5]) begin
                        I2S_DATA <= shift_r[AUDIO_DW-1];
                        shift_r  <= shift_r << 1;
                    end else begin
                        I2S_DATA <= shift_l[AUDIO_DW-1];
                        shift_l  <= shift_l << 1;
                    end
                end else begin
                    I2S_DATA <= 1'b0;
                end
            end

            // in_ready is low whenever pending is set, so these never collide.
            if (frame_load && pending) begin
                pending <= 1'b0;
            end else if (capture) begin
                hold_l  <= left_in;
                hold_r  <= right_in;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: every cycle is compared against a time-based frame model,
// plus table-driven frame vectors and hand sequences for the corner cases.
`timescale 1ns/1ps
module tb_i2s_tx;

    localparam int BH    = 2;
    localparam int DW    = 16;
    localparam int FRAME = 128 * BH;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [31:0]   lw;
        logic [31:0]   rw;
    } vec_t;

    logic          clk_sys;
    logic          reset;
    logic [DW-1:0] left_in;
    logic [DW-1:0] right_in;
    logic          in_valid;
    logic          in_ready;
    logic          underrun;
    logic          I2S_BCK;
    logic          I2S_LRCK;
    logic          I2S_DATA;

    i2s_tx #(.BCK_HALF(BH), .AUDIO_DW(DW)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .left_in  (left_in),
        .right_in (right_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .underrun (underrun),
        .I2S_BCK  (I2S_BCK),
        .I2S_LRCK (I2S_LRCK),
        .I2S_DATA (I2S_DATA)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          m_valid = 0;
    pair_t       pend_q[$];
    pair_t       cur = '0;
    logic        exp_und = 1'b0;
    logic        prev_data, prev_lrck, prev_bck;
    logic [63:0] frame_sr = '0;
    logic [63:0] last_frame = '0;
    int          frame_cnt = 0;
    int          und_cnt = 0;
    logic        last_hs = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slot position within the frame for a given cycle count since reset release.
    function automatic int pos_of(input int c);
        return (63 + c / (2 * BH)) % 64;
    endfunction

    function automatic logic exp_data(input int c, input pair_t pr);
        int            pos;
        int            p;
        logic [DW-1:0] s;
        pos = pos_of(c);
        p   = pos % 32;
        s   = (pos < 32) ? pr.l : pr.r;
        if (p >= 1 && p <= DW) return s[DW-p];
        return 1'b0;
    endfunction

    function automatic logic [31:0] word_of(input logic [DW-1:0] s);
        return 32'(s) << (31 - DW);
    endfunction

    task automatic step();
        logic  hs, macc, rst_edge;
        pair_t in_pair;
        if (m_valid) check("in_ready", 64'(in_ready), 64'(pend_q.size() == 0));
        hs       = in_valid & in_ready;
        macc     = !reset && in_valid && (pend_q.size() == 0);
        in_pair  = '{l: left_in, r: right_in};
        rst_edge = reset;
        @(posedge clk_sys);
        #1;
        last_hs = hs && !rst_edge;
        if (rst_edge) begin
            cyc       = 0;
            pend_q.delete();
            cur       = '0;
            exp_und   = 1'b0;
            m_valid   = 1'b1;
            frame_cnt = 0;
        end else begin
            cyc++;
            exp_und = 1'b0;
            if (cyc % FRAME == 2 * BH) begin
                if (pend_q.size() != 0) cur = pend_q.pop_front();
                else exp_und = 1'b1;
            end
            if (macc) pend_q.push_back(in_pair);
        end
        if (m_valid) begin
            check("bck", 64'(I2S_BCK), 64'((cyc / BH) % 2 == 1));
            check("lrck", 64'(I2S_LRCK), 64'(pos_of(cyc) >= 32));
            check("data", 64'(I2S_DATA), 64'(exp_data(cyc, cur)));
            check("underrun", 64'(underrun), 64'(exp_und));
            if (!rst_edge && cyc % (2 * BH) == BH) begin
                check("data_stable_at_bck_rise", 64'(I2S_DATA), 64'(prev_data));
                frame_sr = {frame_sr[62:0], I2S_DATA};
                if (pos_of(cyc) == 63) begin
                    last_frame = frame_sr;
                    frame_cnt++;
                end
            end
            if (!rst_edge && I2S_LRCK !== prev_lrck)
                check("lrck_only_on_bck_fall", 64'({prev_bck, I2S_BCK}), 64'(2'b10));
        end
        if (underrun === 1'b1) und_cnt++;
        prev_data = I2S_DATA;
        prev_lrck = I2S_LRCK;
        prev_bck  = I2S_BCK;
    endtask

    task automatic present(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int guard;
        guard    = 0;
        left_in  = l;
        right_in = r;
        in_valid = 1'b1;
        do begin
            step();
            guard++;
        end while (!last_hs && guard < 2 * FRAME);
        in_valid = 1'b0;
        check("accept_handshake", 64'(last_hs), 64'(1));
    endtask

    task automatic wait_frames(input int target);
        int guard;
        guard = 0;
        while (frame_cnt < target && guard < 8 * FRAME) begin
            step();
            guard++;
        end
    endtask

    vec_t tbl [5];

    initial begin
        int            u0, f0, hs_cnt, rate;
        logic [DW-1:0] d;

        tbl[0] = '{16'hA55A, 16'h1234, 32'h52AD_0000, 32'h091A_0000};
        tbl[1] = '{16'hFFFF, 16'h0000, 32'h7FFF_8000, 32'h0000_0000};
        tbl[2] = '{16'h8000, 16'h0001, 32'h4000_0000, 32'h0000_8000};
        tbl[3] = '{16'h7FFF, 16'hFFFE, 32'h3FFF_8000, 32'h7FFF_0000};
        tbl[4] = '{16'h0F0F, 16'hF0F0, 32'h0787_8000, 32'h7878_0000};

        reset    = 1'b1;
        in_valid = 1'b0;
        left_in  = '0;
        right_in = '0;
        repeat (3) step();
        reset = 1'b0;

        // Back-to-back frames, first pair presented straight out of reset.
        for (int i = 0; i < 5; i++) begin
            present(tbl[i].l, tbl[i].r);
            wait_frames(i + 2);
            check("tbl_left_word", 64'(last_frame[63:32]), 64'(tbl[i].lw));
            check("tbl_right_word", 64'(last_frame[31:0]), 64'(tbl[i].rw));
        end

        // No new data: the last pair repeats and underrun fires once per frame.
        u0 = und_cnt;
        for (int k = 1; k <= 2; k++) begin
            wait_frames(6 + k);
            check("repeat_left_word", 64'(last_frame[63:32]), 64'(tbl[4].lw));
            check("repeat_right_word", 64'(last_frame[31:0]), 64'(tbl[4].rw));
        end
        check("underrun_per_frame", 64'(und_cnt - u0), 64'(2));

        // Offer a pair exactly on the frame-load edge with nothing pending.
        while (((cyc + 1) % FRAME) != 2 * BH) step();
        left_in  = 16'hC3C3;
        right_in = 16'h3C3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("load_edge_underrun", 64'(underrun), 64'(1));
        check("load_edge_accept", 64'(last_hs), 64'(1));
        f0 = frame_cnt;
        wait_frames(f0 + 1);
        check("load_edge_old_left", 64'(last_frame[63:32]), 64'(tbl[4].lw));
        check("load_edge_old_right", 64'(last_frame[31:0]), 64'(tbl[4].rw));
        wait_frames(f0 + 2);
        check("load_edge_new_left", 64'(last_frame[63:32]), 64'(word_of(16'hC3C3)));
        check("load_edge_new_right", 64'(last_frame[31:0]), 64'(word_of(16'h3C3C)));

        // Continuous in_valid with incrementing data: one acceptance per frame.
        d = 16'h0100;
        present(d, ~d);
        d++;
        left_in  = d;
        right_in = ~d;
        in_valid = 1'b1;
        hs_cnt   = 0;
        f0       = frame_cnt;
        while (frame_cnt < f0 + 4) begin
            step();
            if (last_hs) begin
                hs_cnt++;
                d++;
                left_in  = d;
                right_in = ~d;
            end
        end
        in_valid = 1'b0;
        check("accepts_over_4_frames", 64'(hs_cnt), 64'(4));

        // Reset at bit_cnt=20 with a pair pending.
        wait_frames(frame_cnt + 1);
        while (pos_of(cyc) != 5) step();
        present(16'h1357, 16'h2468);
        while (pos_of(cyc) != 20) step();
        check("pending_before_reset", 64'(in_ready), 64'(0));
        reset = 1'b1;
        step();
        check("rst_bck", 64'(I2S_BCK), 64'(0));
        check("rst_lrck", 64'(I2S_LRCK), 64'(1));
        check("rst_data", 64'(I2S_DATA), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        reset = 1'b0;
        u0 = und_cnt;
        wait_frames(2);
        check("post_reset_frame_zero", last_frame, 64'(0));
        check("post_reset_underrun", 64'(und_cnt - u0), 64'(1));

        // Randomized traffic with per-frame offer rate, including starved frames.
        for (int f = 0; f < 150; f++) begin
            rate = $urandom_range(0, 4);
            repeat (FRAME) begin
                in_valid = ($urandom_range(0, 199) < rate);
                left_in  = DW'($urandom);
                right_in = DW'($urandom);
                step();
            end
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
